// File: rtl/mips_run_ctrl.sv
// Run controller for a MIPS core: IDLE -> HOLD (core reset) -> RUN -> DONE.
// Optional retired-fetch counter is built when MIPS_RUN_CTRL_INSTR_CNT_EN is defined.
module mips_run_ctrl #(
  parameter int          PC_W          = 32,
  parameter int          CNT_W         = 32,
  parameter int          RST_CYCLES    = 4,
  parameter int          STABLE_CYCLES = 8,
  parameter int          MAX_CYCLES    = 100000,
  parameter logic [31:0] HALT_INSTR    = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  output logic             core_rst,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count,
  output logic [PC_W-1:0]  final_pc
);

  typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  L_TO_LAST   = CNT_W'(MAX_CYCLES - 1);
  localparam logic [HOLD_W-1:0] L_HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [STAB_W-1:0] L_STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

  state_t              r_state;
  state_t              w_nextState;
  logic [HOLD_W-1:0]   r_holdCnt;
  logic [STAB_W-1:0]   r_stableCnt;
  logic [STAB_W-1:0]   w_stableNext;
  logic [PC_W-1:0]     r_lastPc;
  logic                r_havePrev;
  logic [CNT_W-1:0]    r_cycleCount;
  logic                r_timeout;
  logic [PC_W-1:0]     r_finalPc;
  logic                w_startRun;
  logic                w_pcMatch;
  logic                w_halt;
  logic                w_timeoutHit;
  logic                w_holdDone;

  // The first valid fetch of a run has no predecessor, so it can never count as a match.
  always_comb begin
    w_startRun   = ((r_state == IDLE) || (r_state == DONE)) && start;
    w_pcMatch    = instr_valid && r_havePrev && (pc == r_lastPc);
    w_stableNext = w_pcMatch ? (r_stableCnt + STAB_W'(1)) : '0;
    w_halt       = (r_state == RUN) && instr_valid &&
                   ((instr == HALT_INSTR) || (w_stableNext == L_STAB_LAST));
    w_timeoutHit = (r_state == RUN) && (r_cycleCount == L_TO_LAST);
    w_holdDone   = (r_holdCnt == L_HOLD_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = HOLD;
      HOLD:    if (w_holdDone) w_nextState = RUN;
      RUN:     if (w_halt || w_timeoutHit) w_nextState = DONE;
      DONE:    if (start) w_nextState = HOLD;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    core_rst = (r_state != RUN);
    running  = (r_state == RUN);
    done     = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_holdCnt    <= '0;
      r_stableCnt  <= '0;
      r_lastPc     <= '0;
      r_havePrev   <= 1'b0;
      r_cycleCount <= '0;
      r_timeout    <= 1'b0;
      r_finalPc    <= '0;
    end else if (w_startRun) begin
      r_holdCnt    <= '0;
      r_stableCnt  <= '0;
      r_lastPc     <= '0;
      r_havePrev   <= 1'b0;
      r_cycleCount <= '0;
      r_timeout    <= 1'b0;
    end else if (r_state == HOLD) begin
      r_holdCnt <= r_holdCnt + HOLD_W'(1);
    end else if (r_state == RUN) begin
      if (r_cycleCount != '1) r_cycleCount <= r_cycleCount + CNT_W'(1);
      if (instr_valid) begin
        r_stableCnt <= w_stableNext;
        r_lastPc    <= pc;
        r_havePrev  <= 1'b1;
      end
      // A halt wins over a simultaneous timeout.
      if (w_halt) begin
        r_finalPc <= pc;
      end else if (w_timeoutHit) begin
        r_timeout <= 1'b1;
        r_finalPc <= instr_valid ? pc : r_lastPc;
      end
    end
  end

`ifdef MIPS_RUN_CTRL_INSTR_CNT_EN
  logic [CNT_W-1:0] r_instrCount;

  always_ff @(posedge clk) begin
    if (!rst)                                                   r_instrCount <= '0;
    else if (w_startRun)                                        r_instrCount <= '0;
    else if ((r_state == RUN) && instr_valid && (r_instrCount != '1)) r_instrCount <= r_instrCount + CNT_W'(1);
  end

  assign instr_count = r_instrCount;
`else
  assign instr_count = '0;
`endif

  assign cycle_count = r_cycleCount;
  assign timeout     = r_timeout;
  assign final_pc    = r_finalPc;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Scoreboard bench for mips_run_ctrl: each run's outcome is predicted from per-cycle stimulus
// and checked by a monitor when done rises; also covers HOLD length, restart and mid-run reset.
module tb_mips_run_ctrl;
  localparam int          PC_W          = 32;
  localparam int          CNT_W         = 32;
  localparam int          RST_CYCLES    = 4;
  localparam int          STABLE_CYCLES = 8;
  localparam int          MAX_CYCLES    = 20;
  localparam logic [31:0] HALT          = 32'hFFFF_FFFF;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [PC_W-1:0]  pc;
  logic [31:0]      instr;
  logic             instr_valid;
  logic             core_rst;
  logic             running;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;
  logic [PC_W-1:0]  final_pc;

  int nChecks = 0;
  int nBad    = 0;

  typedef struct {
    logic        to;
    logic [31:0] cyc;
    logic [31:0] ic;
    logic [31:0] fpc;
  } exp_t;
  exp_t expQ[$];

  mips_run_ctrl #(
    .PC_W(PC_W), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES), .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_CYCLES(MAX_CYCLES), .HALT_INSTR(HALT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .instr(instr), .instr_valid(instr_valid),
    .core_rst(core_rst), .running(running), .done(done), .timeout(timeout),
    .cycle_count(cycle_count), .instr_count(instr_count), .final_pc(final_pc)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_core_rst", core_rst, 1);
    checkOutput("rst_running", running, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_timeout", timeout, 0);
    checkOutput("rst_cycle_count", cycle_count, 0);
    checkOutput("rst_instr_count", instr_count, 0);
    checkOutput("rst_final_pc", final_pc, 0);
  endtask

  // Monitor: every rising done must match the oldest predicted run outcome.
  logic prevDone = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done && !prevDone) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", done, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("sb_timeout", timeout, e.to);
        checkOutput("sb_cycle_count", cycle_count, e.cyc);
        checkOutput("sb_instr_count", instr_count, e.ic);
        checkOutput("sb_final_pc", final_pc, e.fpc);
        checkOutput("sb_core_rst", core_rst, 1);
      end
    end
    prevDone = done;
  end

  // kind: 0 halt instr at cycle 10, 1 stable pc 0x40, 2 timeout with gaps, 3 five fetches,
  // 4 random, 5 halt on the timeout cycle, 6 reset during RUN.
  task automatic applyStimulus(input int kind);
    logic        v[MAX_CYCLES];
    logic [31:0] p[MAX_CYCLES];
    logic [31:0] ins[MAX_CYCLES];
    int          endIdx, runLen, nValid;
    logic        havePrev;
    logic [31:0] prevPc;
    exp_t        e;

    for (int k = 0; k < MAX_CYCLES; k++) begin
      v[k]   = 1'b1;
      p[k]   = 32'(32'h1000 + 4 * k);
      ins[k] = $urandom & 32'h7FFF_FFFF;
      case (kind)
        0: if (k == 10) ins[k] = HALT;
        1: p[k] = 32'h40;
        2: if ((k == MAX_CYCLES - 1) || ($urandom_range(0, 3) == 0)) v[k] = 1'b0;
        3: begin
             v[k] = (k <= 4);
             if (k == 4) ins[k] = HALT;
           end
        4: begin
             v[k]   = ($urandom_range(0, 3) != 0);
             p[k]   = ((k > 0) && ($urandom_range(0, 3) != 0)) ? p[k-1]
                      : 32'(32'h100 + 4 * $urandom_range(0, 3));
             ins[k] = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
           end
        5: if (k == MAX_CYCLES - 1) ins[k] = HALT;
        default: ;
      endcase
    end

    // Reference: a run ends at the first valid halt word, at the STABLE_CYCLES-th
    // consecutive valid fetch of one pc, or after MAX_CYCLES cycles of RUN.
    endIdx = -1; runLen = 0; nValid = 0; havePrev = 1'b0; prevPc = '0;
    e.to = 1'b0; e.fpc = '0;
    for (int k = 0; k < MAX_CYCLES && endIdx < 0; k++) begin
      if (v[k]) begin
        runLen   = (havePrev && (p[k] == prevPc)) ? runLen + 1 : 1;
        havePrev = 1'b1;
        prevPc   = p[k];
        nValid++;
        if ((ins[k] == HALT) || (runLen >= STABLE_CYCLES)) begin
          endIdx = k;
          e.fpc  = p[k];
        end
      end
      if ((endIdx < 0) && (k == MAX_CYCLES - 1)) begin
        endIdx = k;
        e.to   = 1'b1;
        e.fpc  = prevPc;
      end
    end
    e.cyc = 32'(endIdx + 1);
`ifdef MIPS_RUN_CTRL_INSTR_CNT_EN
    e.ic = 32'(nValid);
`else
    e.ic = '0;
`endif
    if (kind == 6) endIdx = 2;
    else           expQ.push_back(e);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("hold_cycle_count", cycle_count, 0);
    checkOutput("hold_instr_count", instr_count, 0);
    checkOutput("hold_timeout", timeout, 0);
    checkOutput("hold_done", done, 0);
    for (int i = 0; i < RST_CYCLES; i++) begin
      checkOutput("hold_core_rst", core_rst, 1);
      checkOutput("hold_running", running, 0);
      start       = 1'($urandom_range(0, 1));
      instr_valid = 1'($urandom_range(0, 1));
      pc          = 32'h40;
      instr       = HALT;
      @(posedge clk); #1;
    end
    checkOutput("run_running", running, 1);
    checkOutput("run_core_rst", core_rst, 0);

    for (int k = 0; k <= endIdx; k++) begin
      instr_valid = v[k];
      pc          = p[k];
      instr       = ins[k];
      start       = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    start       = 1'b0;
    instr_valid = 1'b0;

    if (kind == 6) begin
      rst = 1'b0;
      @(posedge clk); #1;
      checkResetOutputs();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("abort_idle_done", done, 0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        instr_valid = 1'($urandom_range(0, 1));
        pc          = $urandom;
        instr       = $urandom;
        @(posedge clk); #1;
      end
      instr_valid = 1'b0;
      checkOutput("done_hold_done", done, 1);
      checkOutput("done_hold_running", running, 0);
      checkOutput("done_hold_cycle_count", cycle_count, e.cyc);
      checkOutput("done_hold_final_pc", final_pc, e.fpc);
      checkOutput("done_hold_timeout", timeout, e.to);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; instr_valid = 1'b0; pc = '0; instr = '0;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs();
    rst = 1'b1;

    applyStimulus(0);
    applyStimulus(1);
    applyStimulus(2);
    applyStimulus(5);
    applyStimulus(3);
    repeat (8) applyStimulus(4);
    applyStimulus(6);
    applyStimulus(0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("queue_drained", 64'(expQ.size()), 0);
    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end
endmodule
